mem_cache_ctrl: RTL and testbench
=================================

MEM_CACHE_CTRL -- requirements
Module: mem_cache_ctrl

Interface
REQ-001 The block SHALL use one clock, `clk`; reset `rst` SHALL be asynchronous and active-high.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 Addr  input  16  byte address from the memory stage; bit 0 must be 0.
REQ-005 DataIn  input  16  store data.
REQ-006 Rd  input  1  load request.
REQ-007 Wr  input  1  store request.
REQ-008 DataOut  output  16  load data; valid only while Done=1.
REQ-009 Done  output  1  one-cycle pulse; the request has completed.
REQ-010 Stall  output  1  controller busy; the processor holds PC and pipeline state.
REQ-011 CacheHit  output  1  high together with Done when the request hit.
REQ-012 err  output  1  illegal request; ORed into the processor err.
REQ-013 mem_addr  output  16  backing-memory word address.
REQ-014 mem_wdata  output  16  backing-memory write data.
REQ-015 mem_rd, mem_wr  output  1 each  backing-memory strobes; held until mem_ack.
REQ-016 mem_rdata  input  16  backing-memory read data; valid with mem_ack.
REQ-017 mem_ack  input  1  backing-memory completion; variable latency, at least 1 cycle.

Function
REQ-018 Geometry SHALL be direct-mapped, 64 one-word lines, write-back, write-allocate.
- Index = Addr[6:1].
- Tag = Addr[15:7].
- Each line holds valid, dirty, 9-bit tag and 16-bit data.
REQ-019 The FSM SHALL have states IDLE, COMPARE, WRITEBACK, ALLOCATE and FILL.
REQ-020 In IDLE, exactly one of Rd/Wr with Addr[0]=0 SHALL be latched (Addr, DataIn, op) and move the FSM to COMPARE.
REQ-021 Rd=Wr=1, or Addr[0]=1 with Rd|Wr, SHALL pulse err for one cycle.
- No state change and no Done.
REQ-022 COMPARE hit (valid and tag match) SHALL complete the request in that cycle.
- Done=1 and CacheHit=1.
- Load: DataOut=line data.
- Store: line data=DataIn and dirty=1.
- Next state IDLE.
- Total latency: request cycle plus 1.
REQ-023 COMPARE miss with a dirty victim SHALL go to WRITEBACK; with a clean or invalid victim SHALL go to ALLOCATE.
REQ-024 WRITEBACK SHALL drive mem_wr=1, mem_addr={victim tag, index, 1'b0} and mem_wdata=victim data until mem_ack, then go to ALLOCATE.
REQ-025 ALLOCATE SHALL drive mem_rd=1 and mem_addr={Addr[15:1], 1'b0} until mem_ack, then capture mem_rdata and go to FILL.
REQ-026 FILL SHALL write the line in one cycle, then complete the request.
- Line write: valid=1, tag=new tag, dirty=0; data=mem_rdata, or DataIn for a store (then dirty=1).
- Completion: Done=1, CacheHit=0, DataOut=fill data; next state IDLE.
REQ-027 Stall SHALL be 1 in every state except IDLE, and SHALL be 0 in the cycle Done is asserted.
REQ-028 Rd/Wr/Addr changes while the FSM is not in IDLE SHALL be ignored.
REQ-029 mem_rd and mem_wr SHALL never be asserted together, and SHALL deassert in the cycle after mem_ack.
REQ-030 A mem_ack arriving outside WRITEBACK/ALLOCATE SHALL be ignored.

Reset
REQ-031 Reset SHALL force the following, immediately and regardless of the current state, including mid-WRITEBACK or mid-ALLOCATE:
- FSM to IDLE.
- All valid and dirty bits to 0.
- Done, Stall, CacheHit, err, mem_rd and mem_wr to 0.
- DataOut, mem_addr and mem_wdata to 16'h0000.
REQ-032 Dirty data lost by reset SHALL NOT be written back.
REQ-033 Line data and tag arrays SHALL need no reset.

Configuration
REQ-034 With CACHE_STATS_EN defined, the block SHALL add 16-bit outputs hit_count and miss_count.
- Each increments on Done, according to CacheHit.
- Each saturates at 16'hFFFF and is cleared by rst.
REQ-035 Without CACHE_STATS_EN, those ports and counters SHALL NOT exist; all other behaviour is identical.

Structure
REQ-036 Package mem_cache_pkg SHALL hold:
- the FSM state typedef;
- INDEX_W=6, TAG_W=9, LINES=64;
- the index/tag extraction constants.
REQ-037 The valid/dirty/tag/data storage SHALL be the single sub-module cache_array (one read port, one write port, synchronous write, combinational read).
- The FSM stays in mem_cache_ctrl.

Verification
REQ-038 The bench SHALL cover these directed scenarios:
- Cold load: reset, Rd Addr=16'h0040, mem_rdata=16'hBEEF, mem_ack after 3 cycles -> Done with CacheHit=0, DataOut=16'hBEEF; repeated Rd -> Done next cycle with CacheHit=1.
- Store hit: Wr Addr=16'h0040 DataIn=16'h1234, then Rd 16'h0040 -> hit, DataOut=16'h1234, no mem_rd/mem_wr.
- Dirty eviction: after the store, Rd Addr=16'h0440 (same index, new tag) -> mem_wr with mem_addr=16'h0040, mem_wdata=16'h1234, then mem_rd with mem_addr=16'h0440.
- Error: Rd=Wr=1 -> err pulse, no Done; Rd Addr=16'h0041 -> err pulse.
- Reset mid-ALLOCATE: mem_rd high, rst asserted -> mem_rd=0, Stall=0 at once; Rd 16'h0440 afterwards -> miss.
- CACHE_STATS_EN: 2 hits and 3 misses -> hit_count=2, miss_count=3.

Source files
------------

// File: rtl/mem_cache_pkg.sv
// mem_cache_pkg: shared types and geometry for the direct-mapped data cache controller.
//   state_e       FSM state encoding used by mem_cache_ctrl
//   INDEX_W/TAG_W/LINES, index/tag bit positions, and address helpers
package mem_cache_pkg;

  localparam int unsigned INDEX_W   = 6;
  localparam int unsigned TAG_W     = 9;
  localparam int unsigned LINES     = 64;
  localparam int unsigned INDEX_LSB = 1;
  localparam int unsigned INDEX_MSB = 6;
  localparam int unsigned TAG_LSB   = 7;
  localparam int unsigned TAG_MSB   = 15;

  typedef enum logic [2:0] {
    StIdle,
    StCompare,
    StWriteback,
    StAllocate,
    StFill
  } state_e;

  function automatic logic [INDEX_W-1:0] addr_index(input logic [15:0] addr);
    return addr[INDEX_MSB:INDEX_LSB];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [15:0] addr);
    return addr[TAG_MSB:TAG_LSB];
  endfunction

endpackage

// File: rtl/mem_cache_ctrl_if.sv
// mem_cache_ctrl_if: processor-side request bus plus backing-memory bus of the cache controller.
//   slave  : view taken by mem_cache_ctrl (requests/mem responses in, results/mem strobes out)
//   master : view taken by the processor / memory environment
interface mem_cache_ctrl_if;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  logic        err;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  Addr, DataIn, Rd, Wr, mem_rdata, mem_ack,
    output DataOut, Done, Stall, CacheHit, err, mem_addr, mem_wdata, mem_rd, mem_wr
  );

  modport master (
    output Addr, DataIn, Rd, Wr, mem_rdata, mem_ack,
    input  DataOut, Done, Stall, CacheHit, err, mem_addr, mem_wdata, mem_rd, mem_wr
  );
endinterface

// File: rtl/cache_array.sv
// cache_array: valid/dirty/tag/data storage for 64 one-word lines.
//   clk, rst          clock, asynchronous active-high reset (clears valid and dirty only)
//   rd_index -> rd_*  combinational read port
//   wr_en, wr_*       synchronous write port; a write always marks the line valid
module cache_array import mem_cache_pkg::*; (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [15:0]        rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic               wr_dirty,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [15:0]        wr_data
);

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [15:0]      data_q [LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
      dirty_q[wr_index] <= wr_dirty;
    end
  end

  // Tag and data are meaningless until valid is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/mem_cache_ctrl.sv
// mem_cache_ctrl: direct-mapped, write-back, write-allocate cache controller (64 x 16-bit lines).
//   clk, rst   clock, asynchronous active-high reset
//   bus        mem_cache_ctrl_if.slave: processor request/response and backing-memory handshake
//   hit_count, miss_count  saturating completion counters, present only with CACHE_STATS_EN
module mem_cache_ctrl import mem_cache_pkg::*; (
  input  logic                  clk,
  input  logic                  rst,
  mem_cache_ctrl_if.slave       bus
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
`endif
);

  state_e state_q, state_d;
  logic [15:0] addr_q, din_q, fill_q;
  logic        wr_q;

  logic               rd_valid, rd_dirty;
  logic [TAG_W-1:0]   rd_tag;
  logic [15:0]        rd_data;
  logic               wr_en, wr_dirty;
  logic [15:0]        wr_data;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;

  logic        latch, hit, req_ok, req_bad;
  logic        done, cache_hit, stall, err;
  logic        mem_rd, mem_wr;
  logic [15:0] data_out, mem_addr, mem_wdata;

  assign index   = addr_index(addr_q);
  assign tag     = addr_tag(addr_q);
  assign hit     = rd_valid && (rd_tag == tag);
  assign req_ok  = (bus.Rd ^ bus.Wr) && !bus.Addr[0];
  assign req_bad = (bus.Rd || bus.Wr) && ((bus.Rd && bus.Wr) || bus.Addr[0]);

  cache_array u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (index),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_index (index),
    .wr_dirty (wr_dirty),
    .wr_tag   (tag),
    .wr_data  (wr_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      din_q   <= '0;
      wr_q    <= 1'b0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        addr_q <= bus.Addr;
        din_q  <= bus.DataIn;
        wr_q   <= bus.Wr;
      end
      if (state_q == StAllocate && bus.mem_ack) begin
        fill_q <= bus.mem_rdata;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    latch     = 1'b0;
    done      = 1'b0;
    cache_hit = 1'b0;
    stall     = 1'b1;
    err       = 1'b0;
    data_out  = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    wr_en     = 1'b0;
    wr_dirty  = 1'b0;
    wr_data   = fill_q;
    unique case (state_q)
      StIdle: begin
        stall = 1'b0;
        if (req_ok) begin
          latch   = 1'b1;
          state_d = StCompare;
        end else begin
          // err is combinational; keep it quiet while reset holds the FSM in idle
          err = req_bad && !rst;
        end
      end
      StCompare: begin
        if (hit) begin
          done      = 1'b1;
          cache_hit = 1'b1;
          stall     = 1'b0;
          data_out  = rd_data;
          if (wr_q) begin
            wr_en    = 1'b1;
            wr_dirty = 1'b1;
            wr_data  = din_q;
          end
          state_d = StIdle;
        end else if (rd_valid && rd_dirty) begin
          state_d = StWriteback;
        end else begin
          state_d = StAllocate;
        end
      end
      StWriteback: begin
        mem_wr    = 1'b1;
        mem_addr  = {rd_tag, index, 1'b0};
        mem_wdata = rd_data;
        if (bus.mem_ack) state_d = StAllocate;
      end
      StAllocate: begin
        mem_rd   = 1'b1;
        // addr_q[0] is always 0: misaligned requests are never latched
        mem_addr = addr_q;
        if (bus.mem_ack) state_d = StFill;
      end
      StFill: begin
        wr_en    = 1'b1;
        wr_dirty = wr_q;
        wr_data  = wr_q ? din_q : fill_q;
        done     = 1'b1;
        stall    = 1'b0;
        data_out = wr_data;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.Done      = done;
  assign bus.CacheHit  = cache_hit;
  assign bus.Stall     = stall;
  assign bus.err       = err;
  assign bus.DataOut   = data_out;
  assign bus.mem_rd    = mem_rd;
  assign bus.mem_wr    = mem_wr;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (done) begin
      if (cache_hit) begin
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end else begin
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_cache_ctrl.sv
// tb_mem_cache_ctrl: directed scoreboard bench for mem_cache_ctrl. Expected responses and
// backing-memory transactions are queued by the stimulus; monitor processes pop and compare.
// Build with CACHE_STATS_EN defined to also check hit_count/miss_count.
module tb_mem_cache_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_cache_ctrl_if bus ();

`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  mem_cache_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          is_err;
    bit          chk_data;
    logic [15:0] data;
    logic        hit;
  } resp_t;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } mop_t;

  resp_t       exp_q[$];
  mop_t        mexp_q[$];
  logic [15:0] mem_model [logic [15:0]];
  bit          hold_rd = 1'b0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void push_resp(input bit is_err, input bit chk, input logic [15:0] d,
                                    input logic h);
    resp_t r;
    r.is_err = is_err; r.chk_data = chk; r.data = d; r.hit = h;
    exp_q.push_back(r);
  endfunction

  function automatic void push_mop(input bit wr, input logic [15:0] a, input logic [15:0] d);
    mop_t m;
    m.wr = wr; m.addr = a; m.wdata = d;
    mexp_q.push_back(m);
  endfunction

  // Response monitor: every Done or err pulse must match the next queued expectation.
  always @(negedge clk) begin
    resp_t e;
    if (!rst) begin
      if (bus.Done || bus.err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_response", {30'd0, bus.Done, bus.err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("resp_is_err", bus.err, e.is_err);
          if (!e.is_err) begin
            check("cache_hit", bus.CacheHit, e.hit);
            check("stall_at_done", bus.Stall, 1'b0);
            if (e.chk_data) check("data_out", bus.DataOut, e.data);
          end
        end
      end
      if (bus.mem_rd && bus.mem_wr) check("mem_rd_wr_exclusive", 1'b1, 1'b0);
    end
  end

  // Backing-memory responder: acks after 3 cycles and checks each transaction on ack.
  initial begin
    int   cnt;
    bit   last_rd;
    mop_t m;
    cnt = 0;
    last_rd = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.mem_ack = 1'b0;
        cnt = 0;
      end else if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        cnt = 0;
        if (last_rd) check("mem_rd_drop_after_ack", bus.mem_rd, 1'b0);
      end else if (bus.mem_rd || bus.mem_wr) begin
        cnt++;
        if (cnt >= 3 && !(bus.mem_rd && hold_rd)) begin
          if (mexp_q.size() == 0) begin
            check("unexpected_mem_op", {bus.mem_wr, bus.mem_addr}, 32'd0);
          end else begin
            m = mexp_q.pop_front();
            check("mem_is_wr", bus.mem_wr, m.wr);
            check("mem_addr", bus.mem_addr, m.addr);
            if (m.wr) check("mem_wdata", bus.mem_wdata, m.wdata);
          end
          check("stall_in_mem", bus.Stall, 1'b1);
          if (bus.mem_wr) begin
            mem_model[bus.mem_addr] = bus.mem_wdata;
          end else begin
            bus.mem_rdata = mem_model.exists(bus.mem_addr) ? mem_model[bus.mem_addr] : 16'h0000;
          end
          last_rd = bus.mem_rd;
          bus.mem_ack = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic do_req(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, input bit noise, output int lat);
    @(posedge clk); #1;
    bus.Rd = rd; bus.Wr = wr; bus.Addr = a; bus.DataIn = d;
    @(posedge clk); #1;
    if (noise) begin
      bus.Rd = 1'b1; bus.Wr = 1'b1; bus.Addr = 16'h0441; bus.DataIn = 16'hFFFF;
    end else begin
      bus.Rd = 1'b0; bus.Wr = 1'b0;
    end
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus.Done) begin
        lat = i;
        break;
      end
    end
    bus.Rd = 1'b0; bus.Wr = 1'b0; bus.Addr = '0; bus.DataIn = '0;
    if (lat == 0) check("done_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_err(input logic rd, input logic wr, input logic [15:0] a);
    @(posedge clk); #1;
    bus.Rd = rd; bus.Wr = wr; bus.Addr = a;
    @(posedge clk); #1;
    bus.Rd = 1'b0; bus.Wr = 1'b0; bus.Addr = '0;
    @(negedge clk);
    check("stall_after_err", bus.Stall, 1'b0);
  endtask

  initial begin
    int lat;
    bus.Rd = 1'b0; bus.Wr = 1'b0; bus.Addr = '0; bus.DataIn = '0;
    mem_model[16'h0040] = 16'hBEEF;
    mem_model[16'h0440] = 16'h5A5A;

    repeat (2) @(posedge clk); #1;
    check("rst_stall", bus.Stall, 1'b0);
    check("rst_done", bus.Done, 1'b0);
    check("rst_mem_rd", bus.mem_rd, 1'b0);
    check("rst_mem_wr", bus.mem_wr, 1'b0);
    check("rst_data_out", bus.DataOut, 16'h0000);
    check("rst_mem_addr", bus.mem_addr, 16'h0000);
    rst = 1'b0;

    // Cold load, with request-line noise while busy
    push_mop(1'b0, 16'h0040, 16'h0);
    push_resp(1'b0, 1'b1, 16'hBEEF, 1'b0);
    do_req(1'b1, 1'b0, 16'h0040, 16'h0, 1'b1, lat);
    push_resp(1'b0, 1'b1, 16'hBEEF, 1'b1);
    do_req(1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, lat);
    check("load_hit_latency", lat, 1);

    // Store hit, then read it back
    push_resp(1'b0, 1'b0, 16'h0, 1'b1);
    do_req(1'b0, 1'b1, 16'h0040, 16'h1234, 1'b0, lat);
    check("store_hit_latency", lat, 1);
    push_resp(1'b0, 1'b1, 16'h1234, 1'b1);
    do_req(1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, lat);

    // Dirty eviction: same index, tag 8
    push_mop(1'b1, 16'h0040, 16'h1234);
    push_mop(1'b0, 16'h0440, 16'h0);
    push_resp(1'b0, 1'b1, 16'h5A5A, 1'b0);
    do_req(1'b1, 1'b0, 16'h0440, 16'h0, 1'b0, lat);

    // Illegal requests
    push_resp(1'b1, 1'b0, 16'h0, 1'b0);
    do_err(1'b1, 1'b1, 16'h0040);
    push_resp(1'b1, 1'b0, 16'h0, 1'b0);
    do_err(1'b1, 1'b0, 16'h0041);
    push_resp(1'b1, 1'b0, 16'h0, 1'b0);
    do_err(1'b0, 1'b1, 16'h0443);

    // Dirty the line, then reset during the allocate of a conflicting miss
    push_resp(1'b0, 1'b0, 16'h0, 1'b1);
    do_req(1'b0, 1'b1, 16'h0440, 16'h9999, 1'b0, lat);
    hold_rd = 1'b1;
    push_mop(1'b1, 16'h0440, 16'h9999);
    @(posedge clk); #1;
    bus.Rd = 1'b1; bus.Addr = 16'h0140;
    @(posedge clk); #1;
    bus.Rd = 1'b0; bus.Addr = '0;
    for (int i = 0; i < 40 && !bus.mem_rd; i++) @(negedge clk);
    check("alloc_reached", bus.mem_rd, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_alloc_mem_rd", bus.mem_rd, 1'b0);
    check("rst_mid_alloc_stall", bus.Stall, 1'b0);
    check("rst_mid_alloc_mem_addr", bus.mem_addr, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    hold_rd = 1'b0;

    // Lines invalid after reset: miss with no writeback of the lost dirty data
    push_mop(1'b0, 16'h0440, 16'h0);
    push_resp(1'b0, 1'b1, 16'h9999, 1'b0);
    do_req(1'b1, 1'b0, 16'h0440, 16'h0, 1'b0, lat);
    push_resp(1'b0, 1'b1, 16'h9999, 1'b1);
    do_req(1'b1, 1'b0, 16'h0440, 16'h0, 1'b0, lat);
    push_mop(1'b0, 16'h0040, 16'h0);
    push_resp(1'b0, 1'b1, 16'h1234, 1'b0);
    do_req(1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, lat);
    push_resp(1'b0, 1'b1, 16'h1234, 1'b1);
    do_req(1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, lat);
    // Store miss: allocate, line filled with the store data
    push_mop(1'b0, 16'h0440, 16'h0);
    push_resp(1'b0, 1'b0, 16'h0, 1'b0);
    do_req(1'b0, 1'b1, 16'h0440, 16'h7777, 1'b0, lat);
`ifdef CACHE_STATS_EN
    @(negedge clk);
    check("hit_count", hit_count, 16'd2);
    check("miss_count", miss_count, 16'd3);
`endif
    push_resp(1'b0, 1'b1, 16'h7777, 1'b1);
    do_req(1'b1, 1'b0, 16'h0440, 16'h0, 1'b0, lat);
    check("store_fill_hit_latency", lat, 1);

    repeat (3) @(negedge clk);
    check("resp_queue_drained", exp_q.size(), 0);
    check("mem_queue_drained", mexp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
